count_capture: RTL and testbench
================================

# count_capture

Downstream consumer of the free-running 2-bit counter output. Extends the narrow wrapping count into a wider timestamp by counting wraps. On each rising edge of a trigger input it captures that timestamp into a small FIFO, drained through a valid/ready interface. Sits between the counter and any event-logging or readback logic.

## Interface
- `WIDTH`, default 2: width of the incoming count.
- `EXT_WIDTH`, default 8: width of the wrap-extension counter.
- `DEPTH`, default 4: number of FIFO entries. Must be a power of 2 and at least 2.
- `clk` in, 1: clock.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `count_i` in, `WIDTH`: free-running count from the upstream counter.
- `trig_i` in, 1: event input, synchronous to `clk`.
- `clear_i` in, 1: synchronous flush of the FIFO and the overflow flag.
- `ts_o` out, `EXT_WIDTH+WIDTH`: head-of-FIFO timestamp, formatted as {ext, count}.
- `ts_valid_o` out, 1: `ts_o` holds a valid entry.
- `ts_ready_i` in, 1: consumer accepts `ts_o`.
- `level_o` out, `$clog2(DEPTH)+1`: current FIFO occupancy.
- `overflow_o` out, 1: sticky flag; at least one event was dropped.

## Operation
- **Wrap detect:** `wrap = (count_i < count_prev_q)`. `count_prev_q` registers `count_i` every cycle.
- **Extension:** `ext_q <= ext_q + wrap`, modulo 2^`EXT_WIDTH`.
- **Stamp:** `stamp = {ext_q + wrap, count_i}`. A capture in the wrap cycle therefore already carries the incremented extension.
- **Edge detect:** `trig_q` registers `trig_i`. `event = trig_i & ~trig_q`. A held-high trigger produces exactly one event.
- **Pop:** `pop = ts_valid_o & ts_ready_i`.
- **Push:** `push = event & (~full | pop)`. When full with a simultaneous pop, the push is accepted.
- **Drop:** `event & full & ~pop` drops the event and sets `overflow_o`.
- **FIFO:** show-ahead. `ts_o` is the head entry whenever `ts_valid_o = 1`. `ts_valid_o = (level != 0)`.
- **Pointers:** read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. Occupancy is tracked by a separate `level` counter.
- **Clear:** `clear_i` has highest priority.
  - Resets pointers and level, clears `overflow_o`.
  - An event in the same cycle is discarded and does not set overflow.
  - A pop in the same cycle is ignored.
  - `ext_q`, `count_prev_q` and `trig_q` are unaffected.
- **Ready before valid:** `ts_ready_i` asserted with `ts_valid_o = 0` has no effect.
- **Data stability:** `ts_o` may change only after a pop or after a push into an empty FIFO.

## Timing
- **Reset values:** all outputs 0. `ts_o` reads 0 while empty after reset. Internal `ext_q`, `count_prev_q`, `trig_q` and pointers are also 0.
- **Reset mid-operation:** asynchronous assertion clears all state immediately. Pending entries are lost.
- **Capture latency:** an event in cycle N gives `ts_valid_o = 1` and `ts_o = stamp(N)` in cycle N+1 when the FIFO was empty.
- **Level:** `level_o` updates the cycle after a push or pop. Simultaneous push and pop leave it unchanged.
- **Overflow:** `overflow_o` rises the cycle after the dropped event and holds until `clear_i` or reset.
- **First cycle after reset:** because `count_prev_q = 0`, no wrap is detected in that cycle.
- **Throughput:** one push and one pop per cycle.

## Structure
- **Package `count_capture_pkg`:**
  - default parameter constants;
  - a `function` computing the level width;
  - a `typedef` for the stamp struct {ext, count}.
- **Sub-module `count_capture_fifo`:** synchronous show-ahead FIFO with parameters `DW` and `DEPTH`.
  - Ports: `clk`, `rst_n`, `clr`, `push`, `wdata`, `pop`, `rdata`, `empty`, `full`, `level`.
- **Top level:** wrap extension, edge detect, push/drop/overflow logic. Instantiates the FIFO.

## Test plan
1. **Reset:** assert `rst_n` low with 3 entries queued → `ts_valid_o = 0`, `level_o = 0`, `overflow_o = 0` while low and after release.
2. **Single capture:** `count_i` sequence 0,1,2,3,0,1; `trig_i` rises when `count_i = 1` after one wrap → next cycle `ts_valid_o = 1`, `ts_o = 10'h005`; pop with `ts_ready_i = 1` → `level_o = 0`.
3. **Held trigger:** `trig_i` high for 10 cycles → exactly one entry, `level_o = 1`.
4. **Overflow and clear:** `DEPTH = 4`, `ts_ready_i = 0`, 5 trigger edges → `level_o = 4`, `overflow_o = 1`, head is the first stamp. Pulse `clear_i` → `level_o = 0`, `overflow_o = 0`, `ts_valid_o = 0`.
5. **Full with push and pop:** FIFO full, `ts_ready_i = 1` and an event in the same cycle → `level_o` stays 4, `overflow_o` stays 0, new stamp is at the tail.
6. **Extension rollover:** 256 count wraps from reset → `ext_q` returns to 0; a capture in the 256th wrap cycle gives `ts_o = {8'h00, 2'd0}`.

Source files
------------

// File: rtl/count_capture_pkg.sv
// ---------------------------------------------------------------------------
// count_capture_pkg: shared defaults, level-width helper and stamp layout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package count_capture_pkg;

  localparam int DEF_WIDTH     = 2;
  localparam int DEF_EXT_WIDTH = 8;
  localparam int DEF_DEPTH     = 4;

  // Occupancy needs one bit more than the pointers so that "full" is representable.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic [DEF_EXT_WIDTH-1:0] ext;
    logic [DEF_WIDTH-1:0]     count;
  } stamp_t;

endpackage

`default_nettype wire

// File: rtl/count_capture_fifo.sv
// ---------------------------------------------------------------------------
// count_capture_fifo: synchronous show-ahead FIFO with separate level counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module count_capture_fifo
  import count_capture_pkg::*;
#(
  parameter  int DW    = DEF_EXT_WIDTH + DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = level_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push;
  logic          do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Flush wins over any push or pop in the same cycle.
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/count_capture.sv
// ---------------------------------------------------------------------------
// count_capture: extends a wrapping count into a timestamp, captured on trigger
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module count_capture
  import count_capture_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int EXT_WIDTH = DEF_EXT_WIDTH,
  parameter  int DEPTH     = DEF_DEPTH,
  localparam int LW        = level_width(DEPTH),
  localparam int TW        = EXT_WIDTH + WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count_i,
  input  logic             trig_i,
  input  logic             clear_i,
  output logic [TW-1:0]    ts_o,
  output logic             ts_valid_o,
  input  logic             ts_ready_i,
  output logic [LW-1:0]    level_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0]     count_prev_q, count_prev_d;
  logic [EXT_WIDTH-1:0] ext_q, ext_d;
  logic                 trig_q, trig_d;
  logic                 overflow_q, overflow_d;

  logic                 wrap;
  logic [EXT_WIDTH-1:0] ext_next;
  logic [TW-1:0]        stamp;
  logic                 trig_event;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic                 fifo_empty;
  logic                 fifo_full;

  always_comb begin
    wrap         = (count_i < count_prev_q);
    ext_next     = ext_q + EXT_WIDTH'(wrap);
    // Use the post-wrap extension so a capture in the wrap cycle is monotonic.
    stamp        = {ext_next, count_i};
    trig_event   = trig_i & ~trig_q;
    pop          = ts_valid_o & ts_ready_i;
    push         = trig_event & (~fifo_full | pop);
    drop         = trig_event & fifo_full & ~pop;
    overflow_d   = clear_i ? 1'b0 : (overflow_q | drop);
    count_prev_d = count_i;
    ext_d        = ext_next;
    trig_d       = trig_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_prev_q <= '0;
      ext_q        <= '0;
      trig_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      count_prev_q <= count_prev_d;
      ext_q        <= ext_d;
      trig_q       <= trig_d;
      overflow_q   <= overflow_d;
    end
  end

  count_capture_fifo #(
    .DW    (TW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_i),
    .push  (push),
    .wdata (stamp),
    .pop   (pop),
    .rdata (ts_o),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level_o)
  );

  assign ts_valid_o = ~fifo_empty;
  assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_count_capture.sv
// ---------------------------------------------------------------------------
// tb_count_capture: directed bench for count_capture with default parameters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_count_capture;
  import count_capture_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] count_i;
  logic       trig_i;
  logic       clear_i;
  logic [9:0] ts_o;
  logic       ts_valid_o;
  logic       ts_ready_i;
  logic [2:0] level_o;
  logic       overflow_o;

  int n_assert;
  int n_fail;

  // Reference state for the incoming count and the expected stamp of each cycle.
  logic [1:0] cnt;
  logic [1:0] prev_m;
  logic [7:0] ext_m;
  stamp_t     last_stamp;
  stamp_t     s [8];

  count_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_i    (count_i),
    .trig_i     (trig_i),
    .clear_i    (clear_i),
    .ts_o       (ts_o),
    .ts_valid_o (ts_valid_o),
    .ts_ready_i (ts_ready_i),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic r, input logic c);
    logic w;
    trig_i     = t;
    ts_ready_i = r;
    clear_i    = c;
    count_i    = cnt;
    w          = (cnt < prev_m);
    last_stamp.ext   = ext_m + 8'(w);
    last_stamp.count = cnt;
    ext_m      = ext_m + 8'(w);
    prev_m     = cnt;
    @(posedge clk);
    #1;
    cnt = cnt + 2'd1;
  endtask

  task automatic model_reset();
    cnt    = 2'd0;
    prev_m = 2'd0;
    ext_m  = 8'd0;
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    count_i    = 2'd0;
    trig_i     = 1'b0;
    clear_i    = 1'b0;
    ts_ready_i = 1'b0;
    model_reset();

    // Reset values
    #3;
    chk("rst_valid", 32'(ts_valid_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_ovf",   32'(overflow_o), 32'd0);
    chk("rst_ts",    32'(ts_o), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single capture; ready while empty must do nothing
    cyc(1'b0, 1'b1, 1'b0);  // cnt 0
    cyc(1'b0, 1'b1, 1'b0);  // cnt 1
    cyc(1'b0, 1'b1, 1'b0);  // cnt 2
    cyc(1'b0, 1'b1, 1'b0);  // cnt 3
    chk("ready_no_valid_level", 32'(level_o), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);  // cnt 0, wrap
    cyc(1'b1, 1'b0, 1'b0);  // cnt 1, event
    chk("single_valid", 32'(ts_valid_o), 32'd1);
    chk("single_ts",    32'(ts_o), 32'h005);
    chk("single_level", 32'(level_o), 32'd1);
    cyc(1'b1, 1'b1, 1'b0);  // held high, pop
    chk("single_pop_level", 32'(level_o), 32'd0);
    chk("single_pop_valid", 32'(ts_valid_o), 32'd0);

    // Held trigger: one entry only
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    s[0] = last_stamp;
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("held_level", 32'(level_o), 32'd1);
    chk("held_ts",    32'(ts_o), 32'(s[0]));
    cyc(1'b0, 1'b0, 1'b1);
    chk("held_clear_level", 32'(level_o), 32'd0);

    // Overflow and clear
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      s[i] = last_stamp;
      if (i == 3) chk("ovf_before_drop", 32'(overflow_o), 32'd0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    chk("ovf_level", 32'(level_o), 32'd4);
    chk("ovf_flag",  32'(overflow_o), 32'd1);
    chk("ovf_head",  32'(ts_o), 32'(s[0]));
    cyc(1'b0, 1'b0, 1'b1);
    chk("clr_level", 32'(level_o), 32'd0);
    chk("clr_ovf",   32'(overflow_o), 32'd0);
    chk("clr_valid", 32'(ts_valid_o), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      s[i] = last_stamp;
      cyc(1'b0, 1'b0, 1'b0);
    end
    chk("full_level", 32'(level_o), 32'd4);
    cyc(1'b1, 1'b1, 1'b0);
    s[4] = last_stamp;
    chk("pp_level", 32'(level_o), 32'd4);
    chk("pp_ovf",   32'(overflow_o), 32'd0);
    chk("pp_head",  32'(ts_o), 32'(s[1]));
    for (int i = 2; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk($sformatf("pp_drain_%0d", i), 32'(ts_o), 32'(s[i]));
    end
    chk("pp_drain_level", 32'(level_o), 32'd1);

    // Reset mid-operation with three entries queued
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("q3_level", 32'(level_o), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ts_valid_o), 32'd0);
    chk("async_rst_level", 32'(level_o), 32'd0);
    chk("async_rst_ovf",   32'(overflow_o), 32'd0);
    trig_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk("rel_valid", 32'(ts_valid_o), 32'd0);
    chk("rel_level", 32'(level_o), 32'd0);

    // Extension rollover: 256 wraps from reset, wrap N occurs at cycle 4*N
    for (int i = 0; i <= 1020; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("post_rst_ovf", 32'(overflow_o), 32'd0);
    cyc(1'b1, 1'b0, 1'b0);  // cycle 1021: cnt 1, ext 255
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);  // cycle 1024: 256th wrap
    chk("roll_level", 32'(level_o), 32'd2);
    chk("roll_pre",   32'(ts_o), 32'h3FD);
    cyc(1'b0, 1'b1, 1'b0);
    chk("roll_ts",    32'(ts_o), 32'h000);
    chk("roll_valid", 32'(ts_valid_o), 32'd1);
    chk("roll_level_after_pop", 32'(level_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
